// File: rtl/fft_pkg.sv
// Shared types and constants for the mixed-radix (2/3/5) DFT stage sequencer.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SIZE  = 3'd1,
        CHECK = 3'd2,
        ISSUE = 3'd3,
        DRAIN = 3'd4
    } state_e;

    localparam logic [2:0] RADIX2 = 3'd2;
    localparam logic [2:0] RADIX3 = 3'd3;
    localparam logic [2:0] RADIX5 = 3'd5;

    localparam int MAX_STAGE2    = 8;
    localparam int MAX_STAGE3    = 5;
    localparam int MAX_STAGE5    = 2;
    localparam int DEFAULT_MAX_N = 4096;

    // Stage/factor idx maps onto the DIT order: a twos, then b threes, then fives.
    function automatic logic [2:0] radix_of(input logic [3:0] idx,
                                            input logic [3:0] a,
                                            input logic [2:0] b);
        logic [4:0] ab;
        ab = {1'b0, a} + {2'b0, b};
        if ({1'b0, idx} < {1'b0, a})
            return RADIX2;
        else if ({1'b0, idx} < ab)
            return RADIX3;
        else
            return RADIX5;
    endfunction

endpackage

// File: rtl/fft_stage_seq_mul.sv
// Combinational shift-add multiply by 2, 3 or 5 (any other radix passes x through).
module fft_mul235
    import fft_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] x_i,
    input  logic [2:0]   radix_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        unique case (radix_i)
            RADIX2:  y_o = x_i << 1;
            RADIX3:  y_o = x_i + (x_i << 1);
            RADIX5:  y_o = x_i + (x_i << 2);
            default: y_o = x_i;
        endcase
    end

endmodule

// File: rtl/fft_stage_seq.sv
// Stage sequencer for the 2/3/5 DFT engine: sizes N, then issues butterfly descriptors stage by stage.
// Optional perf counters (perf_stall, perf_drain) are built when FFT_STAGE_SEQ_PERF_EN is defined.
module fft_stage_seq
    import fft_pkg::*;
#(
    parameter int IW    = 13,
    parameter int MAX_N = DEFAULT_MAX_N
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [3:0]    cfg_stage2,
    input  logic [2:0]    cfg_stage3,
    input  logic [1:0]    cfg_stage5,
    output logic          bf_valid,
    input  logic          bf_ready,
    output logic [2:0]    bf_radix,
    output logic [IW-1:0] bf_base,
    output logic [IW-1:0] bf_stride,
    output logic          bf_last,
    input  logic          stage_done,
    output logic [3:0]    stage_idx,
    output logic [IW-1:0] fft_size,
    output logic          busy,
    output logic          done,
    output logic          err
`ifdef FFT_STAGE_SEQ_PERF_EN
    ,
    output logic [IW+7:0] perf_stall,
    output logic [IW+7:0] perf_drain
`endif
);

    localparam int PW = IW + 3;

    state_e        state_q, state_d;
    logic [3:0]    a_q, a_d;
    logic [2:0]    b_q, b_d;
    logic [1:0]    c_q, c_d;
    logic [3:0]    fidx_q, fidx_d;
    logic [PW-1:0] prod_q, prod_d, prod_mul;
    logic          big_q, big_d;
    logic [PW-1:0] len_q, len_d, lr;
    logic [IW-1:0] gbase_q, gbase_d;
    logic [IW-1:0] k_q, k_d;
    logic [IW-1:0] fsize_q, fsize_d;
    logic [2:0]    r_q, r_d;
    logic [3:0]    sidx_q, sidx_d;
    logic          done_q, done_d;

    logic [4:0]    total;
    logic [2:0]    fac;
    logic          k_wrap, last_desc, bad;

    assign total = {1'b0, a_q} + {2'b0, b_q} + {3'b0, c_q};
    assign fac   = radix_of(fidx_q, a_q, b_q);

    fft_mul235 #(.W(PW)) u_mul_prod (.x_i(prod_q), .radix_i(fac), .y_o(prod_mul));
    fft_mul235 #(.W(PW)) u_mul_len  (.x_i(len_q),  .radix_i(r_q), .y_o(lr));

    // Once prod passes MAX_N it only grows, so a sticky flag stands in for the wrapped value.
    assign bad       = big_q || (total == 5'd0);
    assign k_wrap    = ({{(PW-IW){1'b0}}, k_q} == len_q - 1'b1);
    assign last_desc = k_wrap && ({{(PW-IW){1'b0}}, gbase_q} + lr == {{(PW-IW){1'b0}}, fsize_q});

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        fidx_d  = fidx_q;
        prod_d  = prod_q;
        big_d   = big_q;
        len_d   = len_q;
        gbase_d = gbase_q;
        k_d     = k_q;
        fsize_d = fsize_q;
        r_d     = r_q;
        sidx_d  = sidx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = cfg_stage2;
                    b_d     = cfg_stage3;
                    c_d     = cfg_stage5;
                    prod_d  = PW'(1);
                    big_d   = 1'b0;
                    fidx_d  = 4'd0;
                    state_d = SIZE;
                end
            end
            SIZE: begin
                if ({1'b0, fidx_q} >= total) begin
                    state_d = CHECK;
                end else begin
                    prod_d = prod_mul;
                    fidx_d = fidx_q + 4'd1;
                    if (prod_mul > PW'(MAX_N))
                        big_d = 1'b1;
                    if ({1'b0, fidx_q} + 5'd1 >= total) begin
                        state_d = CHECK;
                        if (!big_d)
                            fsize_d = prod_d[IW-1:0];
                    end
                end
            end
            CHECK: begin
                if (bad) begin
                    state_d = IDLE;
                end else begin
                    len_d   = PW'(1);
                    gbase_d = '0;
                    k_d     = '0;
                    sidx_d  = 4'd0;
                    r_d     = radix_of(4'd0, a_q, b_q);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bf_ready) begin
                    if (k_wrap) begin
                        k_d     = '0;
                        gbase_d = gbase_q + lr[IW-1:0];
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                    if (last_desc)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (stage_done) begin
                    len_d   = lr;
                    gbase_d = '0;
                    k_d     = '0;
                    sidx_d  = sidx_q + 4'd1;
                    if ({1'b0, sidx_q} + 5'd1 < total) begin
                        r_d     = radix_of(sidx_q + 4'd1, a_q, b_q);
                        state_d = ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            fidx_q  <= '0;
            prod_q  <= '0;
            big_q   <= 1'b0;
            len_q   <= PW'(1);
            gbase_q <= '0;
            k_q     <= '0;
            fsize_q <= '0;
            r_q     <= '0;
            sidx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            fidx_q  <= fidx_d;
            prod_q  <= prod_d;
            big_q   <= big_d;
            len_q   <= len_d;
            gbase_q <= gbase_d;
            k_q     <= k_d;
            fsize_q <= fsize_d;
            r_q     <= r_d;
            sidx_q  <= sidx_d;
            done_q  <= done_d;
        end
    end

    // Descriptor fields are pure register decodes, so they cannot move during a stall.
    assign bf_valid  = (state_q == ISSUE);
    assign bf_radix  = bf_valid ? r_q : 3'd0;
    assign bf_base   = bf_valid ? gbase_q + k_q : '0;
    assign bf_stride = bf_valid ? len_q[IW-1:0] : '0;
    assign bf_last   = bf_valid && last_desc;
    assign stage_idx = sidx_q;
    assign fft_size  = fsize_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = (state_q == CHECK) && bad && !abort;

`ifdef FFT_STAGE_SEQ_PERF_EN
    logic [IW+7:0] stall_q, drain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            drain_q <= '0;
        end else if (state_q == IDLE && start && !abort) begin
            stall_q <= '0;
            drain_q <= '0;
        end else begin
            if (bf_valid && !bf_ready && !(&stall_q))
                stall_q <= stall_q + 1'b1;
            if (state_q == DRAIN && !(&drain_q))
                drain_q <= drain_q + 1'b1;
        end
    end

    assign perf_stall = stall_q;
    assign perf_drain = drain_q;
`endif

endmodule

// File: tb/tb_fft_stage_seq.sv
// Bench for fft_stage_seq: random handshakes checked against a nested-loop descriptor model.
module tb_fft_stage_seq;

    localparam int IW = 13;

    logic          clk = 1'b0;
    logic          rst_n, start, abort;
    logic [3:0]    cfg_stage2;
    logic [2:0]    cfg_stage3;
    logic [1:0]    cfg_stage5;
    logic          bf_valid, bf_ready;
    logic [2:0]    bf_radix;
    logic [IW-1:0] bf_base, bf_stride;
    logic          bf_last, stage_done;
    logic [3:0]    stage_idx;
    logic [IW-1:0] fft_size;
    logic          busy, done, err;
`ifdef FFT_STAGE_SEQ_PERF_EN
    logic [IW+7:0] perf_stall, perf_drain;
`endif

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        int radix;
        int base;
        int stride;
        bit last;
        int stage;
    } desc_t;

    desc_t exp_q[$];

    always #5 clk = ~clk;

    fft_stage_seq #(.IW(IW), .MAX_N(4096)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_stage2 (cfg_stage2),
        .cfg_stage3 (cfg_stage3),
        .cfg_stage5 (cfg_stage5),
        .bf_valid   (bf_valid),
        .bf_ready   (bf_ready),
        .bf_radix   (bf_radix),
        .bf_base    (bf_base),
        .bf_stride  (bf_stride),
        .bf_last    (bf_last),
        .stage_done (stage_done),
        .stage_idx  (stage_idx),
        .fft_size   (fft_size),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef FFT_STAGE_SEQ_PERF_EN
        ,
        .perf_stall (perf_stall),
        .perf_drain (perf_drain)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic fail_now(input string tag);
        nvec++;
        nfail++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    function automatic int size_of(input int a, input int b, input int c);
        int n = 1;
        repeat (a) n = n * 2;
        repeat (b) n = n * 3;
        repeat (c) n = n * 5;
        return n;
    endfunction

    // Every stage walks groups of L*r points; each group holds L butterflies at offsets k.
    task automatic build_model(input int a, input int b, input int c);
        int n, len, r;
        exp_q.delete();
        n   = size_of(a, b, c);
        len = 1;
        for (int s = 0; s < a + b + c; s++) begin
            r = (s < a) ? 2 : (s < a + b) ? 3 : 5;
            for (int g = 0; g < n; g += len * r) begin
                for (int k = 0; k < len; k++) begin
                    desc_t d;
                    d.radix  = r;
                    d.base   = g + k;
                    d.stride = len;
                    d.last   = (g + len * r == n) && (k == len - 1);
                    d.stage  = s;
                    exp_q.push_back(d);
                end
            end
            len = len * r;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},  bf_valid,  0);
        check({tag, "_busy"},   busy,      0);
        check({tag, "_done"},   done,      0);
        check({tag, "_err"},    err,       0);
        check({tag, "_size"},   fft_size,  0);
        check({tag, "_sidx"},   stage_idx, 0);
        check({tag, "_radix"},  bf_radix,  0);
        check({tag, "_base"},   bf_base,   0);
        check({tag, "_stride"}, bf_stride, 0);
        check({tag, "_last"},   bf_last,   0);
    endtask

    // mode: 0 ready always, 1 random ready, 2 three stall cycles per descriptor.
    // intr: 0 none, 1 abort, 2 reset, both fired on the first stage-1 descriptor.
    task automatic run(input int a, input int b, input int c, input int mode,
                       input int sdd, input int intr, output int stalls);
        int    n, ns, cyc, cd, stall_left;
        bit    seen_valid, done_due, exp_done;
        desc_t f;
        build_model(a, b, c);
        n          = size_of(a, b, c);
        ns         = a + b + c;
        stalls     = 0;
        cd         = 0;
        stall_left = 3;
        seen_valid = 1'b0;
        done_due   = 1'b0;
        cyc        = 0;
        start      = 1'b1;
        cfg_stage2 = 4'(a);
        cfg_stage3 = 3'(b);
        cfg_stage5 = 2'(c);
        while (1) begin
            @(negedge clk);
            cyc++;
            start      = 1'b0;
            stage_done = 1'b0;
            abort      = 1'b0;
            exp_done   = done_due;
            done_due   = 1'b0;
            check("done", done, 32'(exp_done));
            if (exp_done) begin
                check("busy_end", busy, 0);
                check("desc_left", exp_q.size(), 0);
                @(negedge clk);
                check("done_once", done, 0);
                return;
            end
            if (cyc > 40000) begin
                fail_now("run_timeout");
                return;
            end
            if (bf_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_desc", bf_base, 32'hFFFF_FFFF);
                    return;
                end
                f = exp_q[0];
                if (!seen_valid) begin
                    check("latency", cyc, ns + 2);
                    check("fft_size", fft_size, n);
                    seen_valid = 1'b1;
                    start      = 1'b1;
                    cfg_stage2 = 4'($urandom_range(0, 8));
                    cfg_stage3 = 3'($urandom_range(0, 5));
                    cfg_stage5 = 2'($urandom_range(0, 2));
                end
                check("radix",  bf_radix,  f.radix);
                check("base",   bf_base,   f.base);
                check("stride", bf_stride, f.stride);
                check("last",   bf_last,   32'(f.last));
                check("stage",  stage_idx, f.stage);
                check("busy",   busy,      1);
                if (intr != 0 && f.stage == 1) begin
                    if (intr == 1) begin
                        abort      = 1'b1;
                        start      = 1'b1;
                        stage_done = 1'b1;
                        bf_ready   = 1'b1;
                        @(negedge clk);
                        abort      = 1'b0;
                        start      = 1'b0;
                        stage_done = 1'b0;
                        check("abort_valid", bf_valid, 0);
                        check("abort_busy",  busy,     0);
                        check("abort_done",  done,     0);
                        check("abort_err",   err,      0);
                        repeat (3) begin
                            @(negedge clk);
                            check("abort_quiet", {busy, done, bf_valid}, 0);
                        end
                    end else begin
                        bf_ready = 1'b0;
                        start    = 1'b0;
                        #2 rst_n = 1'b0;
                        #1;
                        check_all_zero("rst_mid");
                        @(negedge clk);
                        check("rst_hold_busy", busy, 0);
                        rst_n = 1'b1;
                    end
                    return;
                end
            end
            case (mode)
                0:       bf_ready = 1'b1;
                1:       bf_ready = 1'($urandom_range(0, 1));
                default: bf_ready = bf_valid ? (stall_left == 0) : 1'b0;
            endcase
            if (mode == 2 && bf_valid && stall_left > 0)
                stall_left--;
            if (bf_valid && !bf_ready)
                stalls++;
            if (bf_valid && bf_ready) begin
                void'(exp_q.pop_front());
                if (f.last)
                    cd = sdd;
                stall_left = 3;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    stage_done = 1'b1;
                    if (exp_q.size() == 0)
                        done_due = 1'b1;
                end
            end else if (bf_valid && $urandom_range(0, 3) == 0) begin
                stage_done = 1'b1;
            end
        end
    endtask

    task automatic run_err(input int a, input int b, input int c);
        int ns  = a + b + c;
        int due = (ns == 0) ? 2 : ns + 1;
        start      = 1'b1;
        cfg_stage2 = 4'(a);
        cfg_stage3 = 3'(b);
        cfg_stage5 = 2'(c);
        for (int cyc = 1; cyc <= due + 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            check("err_novalid", bf_valid, 0);
            check("err_pulse",   err,      32'(cyc == due));
            check("err_nodone",  done,     0);
        end
        check("err_idle", busy, 0);
    endtask

    initial begin
        int st;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        cfg_stage2 = '0;
        cfg_stage3 = '0;
        cfg_stage5 = '0;
        bf_ready   = 1'b0;
        stage_done = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        start      = 1'b1;
        abort      = 1'b1;
        cfg_stage2 = 4'd2;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", busy, 0);

        run(2, 0, 0, 0, 1, 0, st);
        run(2, 1, 0, 1, 2, 0, st);
        run(0, 1, 1, 2, 1, 0, st);
        run_err(8, 5, 2);
        run_err(0, 0, 0);
        run_err(8, 1, 2);
        run(2, 1, 0, 0, 1, 1, st);
        run(2, 1, 0, 1, 1, 0, st);
        run(2, 1, 0, 2, 2, 2, st);
        run(2, 0, 1, 1, 3, 0, st);

        for (int t = 0; t < 4; t++) begin
            int ra, rb, rc;
            do begin
                ra = $urandom_range(0, 8);
                rb = $urandom_range(0, 5);
                rc = $urandom_range(0, 2);
            end while (ra + rb + rc == 0 || size_of(ra, rb, rc) > 600);
            run(ra, rb, rc, t % 3, 1 + t, 0, st);
        end

        run(8, 1, 1, 0, 1, 0, st);

`ifdef FFT_STAGE_SEQ_PERF_EN
        run(2, 0, 0, 2, 4, 0, st);
        check("perf_stall", perf_stall, st);
        check("perf_drain", perf_drain, 8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
